// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_forward_select.sv
// Per-operand forwarding select for the execute stage; M has priority over WB.
module hazard_forward_select
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = 4
) (
    input  logic [ADDRESSWIDTH-1:0] srcAddressE,
    input  logic [ADDRESSWIDTH-1:0] destAddressM,
    input  logic [ADDRESSWIDTH-1:0] destAddressWB,
    input  logic                    writeEnableM,
    input  logic                    writeEnableWB,
    output logic [1:0]              forwardSelect
);

    always_comb begin
        forwardSelect = FWD_REG;
        if (writeEnableM && (destAddressM == srcAddressE)) begin
            forwardSelect = FWD_MEM;
        end else if (writeEnableWB && (destAddressWB == srcAddressE)) begin
            forwardSelect = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, stall/flush,
// memory-wait watchdog and a saturating stall-cycle counter.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH = 4,
    parameter int unsigned MEMTIMEOUT   = 15,
    parameter int unsigned COUNTWIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressD,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressD,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressE,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressE,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressE,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressM,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressWB,
    input  logic                    writeEnableDE,
    input  logic                    writeEnableDM,
    input  logic                    writeEnableDWB,
    input  logic                    resultSelectorWBE,
    input  logic                    PCSelectorE,
    input  logic                    memRequestM,
    input  logic                    memReadyM,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    stallE,
    output logic                    stallM,
    output logic                    flushD,
    output logic                    flushE,
    output logic [1:0]              forwardAE,
    output logic [1:0]              forwardBE,
    output logic                    memTimeoutError,
    output logic [COUNTWIDTH-1:0]   stallCount
);

    localparam int unsigned WAITWIDTH = $clog2(MEMTIMEOUT + 1);
    localparam logic [WAITWIDTH-1:0] WAITLIMIT = WAITWIDTH'(MEMTIMEOUT);
    localparam logic [WAITWIDTH-1:0] WAITONE = WAITWIDTH'(1);

    state_e                state_q, state_d;
    logic [WAITWIDTH-1:0]  wait_q, wait_d;
    logic                  error_q;
    logic [COUNTWIDTH-1:0] stall_count_q;

    logic [1:0] fwd_a, fwd_b;
    logic       load_use;
    logic       mem_stall;
    logic       hazard_eval;

    hazard_forward_select #(
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_fwd_a (
        .srcAddressE   (reg1AddressE),
        .destAddressM  (regDestinationAddressM),
        .destAddressWB (regDestinationAddressWB),
        .writeEnableM  (writeEnableDM),
        .writeEnableWB (writeEnableDWB),
        .forwardSelect (fwd_a)
    );

    hazard_forward_select #(
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_fwd_b (
        .srcAddressE   (reg2AddressE),
        .destAddressM  (regDestinationAddressM),
        .destAddressWB (regDestinationAddressWB),
        .writeEnableM  (writeEnableDM),
        .writeEnableWB (writeEnableDWB),
        .forwardSelect (fwd_b)
    );

    assign load_use = resultSelectorWBE && writeEnableDE &&
                      ((regDestinationAddressE == reg1AddressD) ||
                       (regDestinationAddressE == reg2AddressD));

    // hazard_eval marks cycles where branch/load-use rules apply; during a memory
    // freeze they are held back until the release cycle.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_stall   = 1'b0;
        hazard_eval = 1'b0;
        unique case (state_q)
            RUN: begin
                if (memRequestM && !memReadyM) begin
                    mem_stall = 1'b1;
                    wait_d    = WAITONE;
                    state_d   = (WAITONE >= WAITLIMIT) ? ERROR : MEM_WAIT;
                end else begin
                    hazard_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!memReadyM) begin
                    mem_stall = 1'b1;
                    wait_d    = wait_q + WAITONE;
                    if (wait_d >= WAITLIMIT) begin
                        state_d = ERROR;
                    end
                end else begin
                    hazard_eval = 1'b1;
                    wait_d      = '0;
                    state_d     = RUN;
                end
            end
            ERROR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        forwardAE = FWD_REG;
        forwardBE = FWD_REG;
        if (!reset) begin
            forwardAE = fwd_a;
            forwardBE = fwd_b;
            stallE    = mem_stall;
            stallM    = mem_stall;
            stallF    = mem_stall || (hazard_eval && !PCSelectorE && load_use);
            stallD    = stallF;
            flushD    = hazard_eval && PCSelectorE;
            flushE    = hazard_eval && (PCSelectorE || load_use);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_q        <= '0;
            error_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == ERROR) begin
                error_q <= 1'b1;
            end
            if (stallF && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + COUNTWIDTH'(1);
            end
        end
    end

    assign memTimeoutError = error_q;
    assign stallCount      = stall_count_q;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central hazard and sequencing controller for the 5-stage pipeline (F, D, E, M, WB). It generates operand-forwarding selects for the execute stage, plus stall and flush enables for the stage flip-flops (`flopenrc` enable/clear). It resolves load-use and taken-branch hazards and freezes the pipeline while the data memory has not acknowledged a request. A watchdog state traps a memory request that never completes, and a saturating counter records stall cycles for performance measurement.

## Interface
Parameters:
- ADDRESSWIDTH, 4, register address width (16 registers)
- MEMTIMEOUT, 15, maximum consecutive memory-wait cycles before error trap
- COUNTWIDTH, 16, width of stall-cycle counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- reg1AddressD, reg2AddressD  in  ADDRESSWIDTH  source registers of instruction in D
- reg1AddressE, reg2AddressE  in  ADDRESSWIDTH  source registers of instruction in E
- regDestinationAddressE, regDestinationAddressM, regDestinationAddressWB  in  ADDRESSWIDTH  destinations per stage
- writeEnableDE, writeEnableDM, writeEnableDWB  in  1  register-file write pending per stage
- resultSelectorWBE  in  1  1 = instruction in E is a load
- PCSelectorE  in  1  1 = taken branch resolved in E
- memRequestM, memReadyM  in  1  data-memory request / completion in M
- stallF, stallD, stallE, stallM  out  1  hold stage register (enable = ~stall)
- flushD, flushE  out  1  synchronous clear of D / E stage register
- forwardAE, forwardBE  out  2  operand select: 00 register file, 01 WB result, 10 M ALU result
- memTimeoutError  out  1  sticky error flag
- stallCount  out  COUNTWIDTH  saturating count of cycles with stallF = 1

## Operation
- All 16 registers are ordinary. There is no zero-register exclusion.
- Forwarding (independent of state):
  - forwardAE = 10 if writeEnableDM and regDestinationAddressM == reg1AddressE.
  - Otherwise forwardAE = 01 if writeEnableDWB and regDestinationAddressWB == reg1AddressE.
  - Otherwise forwardAE = 00.
  - forwardBE is the same using reg2AddressE.
  - M has priority over WB.
- State machine states: RUN, MEM_WAIT, ERROR.
- RUN, with priority highest first:
  1. memRequestM and not memReadyM: stallF/D/E/M = 1, no flush. Next state is MEM_WAIT; the wait counter loads 1.
  2. PCSelectorE: flushD = flushE = 1, no stall.
  3. Load-use, i.e. resultSelectorWBE and writeEnableDE and regDestinationAddressE equals reg1AddressD or reg2AddressD: stallF = stallD = 1, flushE = 1.
  4. Otherwise all stall/flush outputs are 0.
- MEM_WAIT:
  - If memReadyM = 0: stallF/D/E/M = 1 and the counter increments. When the counter reaches MEMTIMEOUT, the next state is ERROR.
  - If memReadyM = 1: stalls are 0 that cycle and rules 2–4 of RUN are evaluated. Next state is RUN; the counter clears.
  - A branch or load-use condition present during the wait is held frozen in E/D. It is acted on in the release cycle, not before.
- ERROR:
  - stallF/D/E/M = 1, flushes 0, memTimeoutError = 1.
  - Only reset exits this state.
- stallCount increments every cycle with stallF = 1 and saturates at all-ones; it never wraps.

## Timing
- forward*, stall*, flush* are combinational from inputs and current state, with zero-cycle latency. They must be valid before the same clock edge.
- State, wait counter, memTimeoutError and stallCount are registered on the rising clock edge.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed instructions.
- A memory request with ready in the same cycle causes no stall and no state change.
- With N wait cycles (N < MEMTIMEOUT), the full stall lasts exactly N cycles.
- Reset, asynchronous and valid at any point including mid-MEM_WAIT:
  - state = RUN, wait counter = 0, memTimeoutError = 0, stallCount = 0.
  - While reset is high, all stall/flush/forward outputs are forced to 0.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - the forward-select constants FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- Sub-module hazard_forward_select is the combinational per-operand forwarding compare, instantiated twice (operand A and operand B).
- The FSM, wait counter and stall counter live in the top module.

## Test plan
- Forwarding: M writes R3 and WB writes R3, reg1AddressE = 3 → forwardAE = 10. With M write disabled → 01. With neither → 00.
- Load-use: E is a load to R5, reg2AddressD = 5 → stallF = stallD = flushE = 1 for exactly 1 cycle, then all 0.
- Branch taken together with a load-use condition → flushD = flushE = 1, stallF = 0.
- Memory wait: memRequestM = 1 with memReadyM = 0 for 3 cycles, then 1 → all stalls high for 3 cycles; stallCount = 3; state returns to RUN.
- Timeout with MEMTIMEOUT = 15 and memReadyM held at 0 → ERROR after 15 wait cycles; memTimeoutError = 1 and stalls stay high. Asserting reset mid-wait returns all outputs and counters to 0.
- Saturation: stallCount preloaded near all-ones (COUNTWIDTH = 4 build) under a continuous stall → stallCount holds at 15 and does not wrap.
